fsqrt_nr: RTL and testbench



---
 rtl/fsqrt_nr.sv | 205 ++++++++++++++++++++
 tb/tb_fsqrt_nr.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_nr.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fsqrt_nr : multi-cycle fp32 sqrt / rsqrt (seed ROM + ITER Newton-Raphson steps)
// Optional: define FSQRT_FLAGS_EN to add out_flags = {invalid, divzero}. Rev 1.0
// -----------------------------------------------------------------------------
module fsqrt_nr #(
  parameter int LUT_BITS = 10,
  parameter int SEED_W   = 12,
  parameter int ITER     = 2,
  parameter int FRAC_W   = 30
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y
`ifdef FSQRT_FLAGS_EN
  ,
  output logic [1:0]  out_flags
`endif
);

  localparam int c_w     = FRAC_W + 2;
  localparam int c_nrom  = 1 << LUT_BITS;
  localparam int c_nhalf = c_nrom / 2;
  localparam logic [1:0]     c_it_last = 2'(ITER - 1);
  localparam logic [c_w-1:0] c_three   = {2'b11, {FRAC_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, SEED, ITER_A, ITER_B, ITER_C, FINAL, DONE} state_t;

  state_t state, next_state;

  logic [30:0]    r_x;
  logic           r_mode;
  logic [c_w-1:0] r_y;
  logic [c_w-1:0] r_t;
  logic [1:0]     r_it;

  // Halved biased exponent, (e + 127) >> 1, split on parity to stay in 8 bits
  function automatic logic [7:0] half_exp(input logic [7:0] e);
    return {1'b0, e[7:1]} + (e[0] ? 8'd64 : 8'd63);
  endfunction

  // Seed ROM: 1/sqrt of each interval midpoint, MSB of the index is exponent parity
  logic [SEED_W-1:0] w_rom [c_nrom];
  for (genvar gi = 0; gi < c_nrom; gi++) begin : g_rom
    localparam real c_mid = (1.0 + (real'(gi % c_nhalf) + 0.5) / real'(c_nhalf))
                            * ((gi >= c_nhalf) ? 1.0 : 2.0);
    localparam int  c_val = $rtoi((2.0 ** SEED_W) / $sqrt(c_mid) + 0.5);
    assign w_rom[gi] = SEED_W'(c_val);
  end

  logic [LUT_BITS-1:0] w_idx;
  logic [SEED_W-1:0]   w_seed;
  logic [c_w-1:0]      w_m1, w_m;
  logic [7:0]          w_ye;

  assign w_idx  = {r_x[23], r_x[22 -: LUT_BITS-1]};
  assign w_seed = w_rom[w_idx];
  assign w_m1   = {2'b01, r_x[22:0], {(FRAC_W-23){1'b0}}};
  assign w_m    = r_x[23] ? w_m1 : {w_m1[c_w-2:0], 1'b0};
  assign w_ye   = half_exp(r_x[30:23]);

  // Operand decode for the single-cycle special / exact path
  logic        w_s, w_zero, w_inf, w_nan, w_invalid, w_exact, w_short;
  logic [7:0]  w_e, w_ye_in;
  logic [22:0] w_f;
  logic [31:0] w_spec_y;

  always_comb begin
    w_s       = in_x[31];
    w_e       = in_x[30:23];
    w_f       = in_x[22:0];
    w_ye_in   = half_exp(w_e);
    w_zero    = (w_e == 8'd0);
    w_inf     = (w_e == 8'hFF) && (w_f == 23'd0);
    w_nan     = (w_e == 8'hFF) && (w_f != 23'd0);
    w_invalid = w_nan || (w_s && !w_zero);
    w_exact   = !w_zero && (w_e != 8'hFF) && (w_f == 23'd0) && w_e[0];
    w_short   = w_invalid || w_zero || w_inf || w_exact;
    w_spec_y  = 32'd0;
    if (w_invalid)
      w_spec_y = 32'h7FC00000;
    else if (w_zero)
      w_spec_y = in_mode ? {w_s, 8'hFF, 23'd0} : {w_s, 31'd0};
    else if (w_inf)
      w_spec_y = in_mode ? 32'd0 : 32'h7F800000;
    else
      w_spec_y = in_mode ? {1'b0, 8'd254 - w_ye_in, 23'd0} : {1'b0, w_ye_in, 23'd0};
  end

  // Shared multiplier
  logic [c_w-1:0]   w_ma, w_mb, w_3mt, w_mul, w_half;
  logic [2*c_w-1:0] w_prod;

  assign w_3mt = c_three - r_t;

  always_comb begin
    w_ma = r_y;
    w_mb = r_y;
    case (state)
      ITER_B: begin w_ma = w_m; w_mb = r_t;   end
      ITER_C: begin w_ma = r_y; w_mb = w_3mt; end
      FINAL:  begin w_ma = w_m; w_mb = r_y;   end
      default: ;
    endcase
  end

  assign w_prod = {{c_w{1'b0}}, w_ma} * {{c_w{1'b0}}, w_mb};
  assign w_mul  = c_w'(w_prod >> FRAC_W);
  assign w_half = c_w'(w_prod >> (FRAC_W + 1));

  // Normalise into [1,2) and round to nearest even
  logic [c_w-1:0] w_v, w_vn;
  logic [7:0]     w_ex;
  logic           w_rnd;
  logic [24:0]    w_m25;
  logic [31:0]    w_fin;

  always_comb begin
    w_v  = r_mode ? r_y : w_mul;
    w_ex = r_mode ? (8'd254 - w_ye) : w_ye;
    w_vn = w_v;
    if (w_v[c_w-1]) begin
      w_ex = w_ex + 8'd1;
    end else if (w_v[c_w-2]) begin
      w_vn = w_v << 1;
    end else begin
      w_vn = w_v << 2;
      w_ex = w_ex - 8'd1;
    end
    w_rnd = w_vn[c_w-25] && ((|w_vn[c_w-26:0]) || w_vn[c_w-24]);
    w_m25 = {1'b0, w_vn[c_w-1 -: 24]} + {24'd0, w_rnd};
    if (w_m25[24]) w_ex = w_ex + 8'd1;
    w_fin = {1'b0, w_ex, (w_m25[24] ? w_m25[23:1] : w_m25[22:0])};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = w_short ? DONE : SEED;
      SEED:    next_state = ITER_A;
      ITER_A:  next_state = ITER_B;
      ITER_B:  next_state = ITER_C;
      ITER_C:  next_state = (r_it == c_it_last) ? FINAL : ITER_A;
      FINAL:   next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x    <= '0;
      r_mode <= 1'b0;
      r_y    <= '0;
      r_t    <= '0;
      r_it   <= '0;
      out_y  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          r_x    <= in_x[30:0];
          r_mode <= in_mode;
          if (w_short) out_y <= w_spec_y;
        end
        SEED: begin
          r_y  <= {{(c_w-FRAC_W){1'b0}}, w_seed, {(FRAC_W-SEED_W){1'b0}}};
          r_it <= '0;
        end
        ITER_A: r_t <= w_mul;
        ITER_B: r_t <= w_mul;
        ITER_C: begin
          r_y <= w_half;
          if (r_it != c_it_last) r_it <= r_it + 2'd1;
        end
        FINAL: out_y <= w_fin;
        default: ;
      endcase
    end
  end

`ifdef FSQRT_FLAGS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      out_flags <= 2'b00;
    else if (in_ready && in_valid)
      out_flags <= {w_invalid, in_mode && w_zero};
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsqrt_nr.sv
`default_nettype none
// tb_fsqrt_nr : directed and model-checked random stimulus for fsqrt_nr
module tb_fsqrt_nr;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
`ifdef FSQRT_FLAGS_EN
  logic [1:0]  out_flags;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fsqrt_nr dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
`ifdef FSQRT_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_ulp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    int d;
    n_tests++;
    d = int'({1'b0, got[30:0]}) - int'({1'b0, exp[30:0]});
    assert ((got[31] === exp[31]) && d >= -1 && d <= 1) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (+/-1 ulp)", tag, got, exp);
    end
  endtask

  // One operation with out_ready high; lat counts the accept edge as cycle 1
  task automatic run_op(input logic [31:0] x, input logic m, output logic [31:0] y, output int lat);
    @(negedge clk);
    in_x = x; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    y = out_y;
    @(posedge clk); #1;
  endtask

  task automatic op(input string tag, input logic [31:0] x, input logic m,
                    input logic [31:0] exp, input int lat_exp, input bit tol);
    logic [31:0] y;
    int lat;
    run_op(x, m, y, lat);
    if (tol) check_ulp(tag, y, exp);
    else     check(tag, y, exp);
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
  endtask

  // Correctly rounded reference built from real arithmetic
  function automatic logic [31:0] ref_fp(input logic [31:0] x, input logic m);
    real v, r;
    int  e, k;
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    r = $sqrt(v);
    if (m) r = 1.0 / r;
    e = 0;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    k = $rtoi((r - 1.0) * 8388608.0 + 0.5);
    if (k == 8388608) begin k = 0; e++; end
    return {1'b0, 8'(e + 127), k[22:0]};
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] y, held;
    logic [31:0] x;
    int lat;
    bit seen;

    rstn = 1'b0; in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_y",     out_y,              32'd0);
    @(negedge clk); rstn = 1'b1;

    op("sqrt_4",    32'h40800000, 1'b0, 32'h40000000, 1, 1'b0);
    op("sqrt_2",    32'h40000000, 1'b0, 32'h3FB504F3, 9, 1'b1);
    op("rsqrt_4",   32'h40800000, 1'b1, 32'h3F000000, 1, 1'b0);
    op("rsqrt_1",   32'h3F800000, 1'b1, 32'h3F800000, 1, 1'b0);
    op("rsqrt_2",   32'h40000000, 1'b1, 32'h3F3504F3, 9, 1'b1);
    op("sqrt_m1",   32'hBF800000, 1'b0, 32'h7FC00000, 1, 1'b0);
`ifdef FSQRT_FLAGS_EN
    check("flags_m1", {30'd0, out_flags}, 32'd2);
`endif
    op("sqrt_den",  32'h00000001, 1'b0, 32'h00000000, 1, 1'b0);
    op("sqrt_nz",   32'h80000000, 1'b0, 32'h80000000, 1, 1'b0);
    op("sqrt_inf",  32'h7F800000, 1'b0, 32'h7F800000, 1, 1'b0);
    op("sqrt_nan",  32'h7FC00001, 1'b0, 32'h7FC00000, 1, 1'b0);
    op("rsqrt_pz",  32'h00000000, 1'b1, 32'h7F800000, 1, 1'b0);
`ifdef FSQRT_FLAGS_EN
    check("flags_rz", {30'd0, out_flags}, 32'd1);
`endif
    op("rsqrt_nz",  32'h80000000, 1'b1, 32'hFF800000, 1, 1'b0);
    op("rsqrt_inf", 32'h7F800000, 1'b1, 32'h00000000, 1, 1'b0);
    op("sqrt_9",    32'h41100000, 1'b0, 32'h40400000, 9, 1'b1);

    // Backpressure: result held, input ignored, then next operand on the edge after release
    @(negedge clk);
    in_x = 32'h40000000; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_x = 32'h3F800000; in_mode = 1'b1;
      @(posedge clk); #1;
      check_ulp("bp_hold_y", out_y, 32'h3FB504F3);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'd0, in_ready},  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_x = 32'h40800000; in_mode = 1'b0;
    @(posedge clk); #1;
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_ready", {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_y",     out_y,              32'h40000000);
    @(posedge clk); #1;

    // Reset in the middle of a normal operation
    @(negedge clk);
    in_x = 32'h40000000; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready},  32'd1);
    @(negedge clk); rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_out", {31'd0, seen},     32'd0);
    check("mid_rst_y",      out_y,             32'd0);
    check("mid_rst_ready2", {31'd0, in_ready}, 32'd1);

    // Random positive normals in both modes against the real-arithmetic reference
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 2000; i++) begin
        x = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
        run_op(x, m[0], y, lat);
        check_ulp(m[0] ? "rnd_rsqrt" : "rnd_sqrt", y, ref_fp(x, m[0]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
